// File: rtl/fifo_unloader.sv
// Pulls words from an upstream FIFO and hands them to a valid/ready consumer
// through a 2-entry skid buffer.
module fifo_unloader #(
  parameter int BITNUMBER = 8,
  parameter int COUNTW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 Fifo_empty,
  input  logic [BITNUMBER-1:0] Fifo_Data_out,
  output logic                 Fifo_rd,
  input  logic                 ready_in,
  output logic                 valid_out,
  output logic [BITNUMBER-1:0] data_out,
  output logic [COUNTW-1:0]    word_count,
  output logic                 idle
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                     state, state_nxt;
  logic [1:0][BITNUMBER-1:0]  mem;
  logic                       head, tail;
  logic [1:0]                 occ;
  logic                       inflight;
  logic                       pop;
  logic [2:0]                 fill;

  assign valid_out = (occ != 2'd0);
  assign data_out  = mem[head];
  assign pop       = valid_out & ready_in;
  assign idle      = (state == IDLE);
  assign fill      = {1'b0, occ} + {2'b00, inflight};

  // A read may be issued into a full pipeline only when a slot frees up in
  // the same cycle; the response lands two edges later, after the pop.
  always_comb begin
    Fifo_rd = 1'b0;
    if (!reset && state == RUN && !Fifo_empty && (fill < 3'd2 || pop))
      Fifo_rd = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)
          state_nxt = RUN;
        else if (occ == 2'd0 && !inflight && !pop)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem        <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      word_count <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= Fifo_rd;
      if (inflight) begin
        mem[tail] <= Fifo_Data_out;
        tail      <= ~tail;
      end
      if (pop) begin
        head       <= ~head;
        word_count <= word_count + COUNTW'(1);
      end
      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_unloader.sv
// Directed bench: upstream FIFO model feeds the unloader, a negedge monitor
// scores every delivered word against the queue of expected words.
module tb_fifo_unloader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       Fifo_empty;
  logic [7:0] Fifo_Data_out = 8'h00;
  logic       Fifo_rd;
  logic       ready_in = 1'b1;
  logic       valid_out;
  logic [7:0] data_out;
  logic [7:0] word_count;
  logic       idle;

  fifo_unloader #(.BITNUMBER(8), .COUNTW(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .Fifo_empty(Fifo_empty),
    .Fifo_Data_out(Fifo_Data_out), .Fifo_rd(Fifo_rd), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .word_count(word_count),
    .idle(idle)
  );

  always #5 clk = ~clk;

  logic [7:0] fmem [0:1023];
  int         wrp = 0;
  int         rdp = 0;
  assign Fifo_empty = (wrp == rdp);

  // Upstream FIFO: read data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (Fifo_rd) begin
      Fifo_Data_out <= fmem[rdp];
      rdp <= rdp + 1;
    end
  end

  logic [7:0] exp_q [$];
  int s_pass = 0, s_total = 0;
  int d_pass = 0, d_total = 0;
  int rd_cnt = 0;

  always @(negedge clk) begin
    if (!reset && Fifo_rd) rd_cnt++;
    if (!reset && valid_out && ready_in) begin
      s_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_word got=%h required=none", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out === e) s_pass++;
        else $display("FAIL sb_data got=%h required=%h", data_out, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    d_total++;
    if (act === req) d_pass++;
    else $display("FAIL %s got=%0h required=%0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] w, input bit expect_it);
    fmem[wrp] = w;
    wrp = wrp + 1;
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic rst();
    reset = 1'b1; enable = 1'b0; ready_in = 1'b1;
    step(); step();
    wrp = rdp;
  endtask

  task automatic wait_drained(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin step(); n++; end
    chk(name, (exp_q.size() == 0), 1);
  endtask

  initial begin
    int r0;
    // reset priority over enable/ready/non-empty FIFO
    #1;
    enable = 1'b1; push(8'h5A, 1'b0);
    step(); chk("rst_rd_blocked", Fifo_rd, 0);
    step(); chk("rst_rd_blocked2", Fifo_rd, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_idle", idle, 1);
    chk("rst_wc", word_count, 0);

    // three words, full throughput
    rst();
    push(8'h11, 1'b1); push(8'h22, 1'b1); push(8'h33, 1'b1);
    enable = 1'b1; reset = 1'b0;
    step(); chk("t1_rd_cycle1", Fifo_rd, 1);
    step(); chk("t1_valid_early", valid_out, 0);
    step(); chk("t1_valid0", valid_out, 1); chk("t1_d0", data_out, 8'h11);
    step(); chk("t1_d1", data_out, 8'h22);
    step(); chk("t1_d2", data_out, 8'h33);
    step(); chk("t1_wc", word_count, 3); chk("t1_empty_after", valid_out, 0);
    chk("t1_sb_done", exp_q.size(), 0);

    // backpressure: only two reads in flight, head held stable
    rst();
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i), 1'b1);
    r0 = rd_cnt;
    ready_in = 1'b0; enable = 1'b1; reset = 1'b0;
    repeat (8) step();
    chk("t2_rd_pulses", rd_cnt - r0, 2);
    chk("t2_valid", valid_out, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold", data_out, 8'hA0);
      step();
    end
    ready_in = 1'b1;
    wait_drained("t2_drained", 40);
    step(); chk("t2_wc", word_count, 8);

    // empty FIFO: never read
    rst();
    r0 = rd_cnt;
    enable = 1'b1; reset = 1'b0;
    repeat (10) step();
    chk("t3_no_rd", rd_cnt - r0, 0);
    chk("t3_valid", valid_out, 0);
    chk("t3_idle", idle, 0);

    // drop enable with one buffered and one in flight
    rst();
    push(8'hC1, 1'b1); push(8'hC2, 1'b1);
    enable = 1'b1; reset = 1'b0;
    step(); step(); step();
    chk("t4_valid_at_drop", valid_out, 1);
    chk("t4_fifo_empty", Fifo_empty, 1);
    r0 = rd_cnt;
    enable = 1'b0;
    begin
      int n;
      n = 0;
      while (!idle && n < 10) begin step(); n++; end
      chk("t4_idle_cycles", (n <= 3), 1);
    end
    chk("t4_idle", idle, 1);
    chk("t4_no_rd", rd_cnt - r0, 0);
    chk("t4_wc", word_count, 2);
    chk("t4_sb_done", exp_q.size(), 0);

    // counter wrap
    rst();
    for (int i = 0; i < 257; i++) push(8'(i * 3 + 1), 1'b1);
    enable = 1'b1; reset = 1'b0;
    wait_drained("t5_drained", 400);
    step(); chk("t5_wc_wrap", word_count, 1);

    // reset with a read in flight discards the response
    rst();
    push(8'hEE, 1'b0);
    enable = 1'b1; reset = 1'b0;
    step(); chk("t6_rd", Fifo_rd, 1);
    step(); reset = 1'b1;
    step(); chk("t6_valid", valid_out, 0); chk("t6_wc", word_count, 0);
    reset = 1'b0; enable = 1'b0;
    repeat (4) step();
    chk("t6_not_delivered", valid_out, 0);
    chk("t6_wc_after", word_count, 0);

    chk("final_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", d_pass + s_pass, d_total + s_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1);
  end

endmodule
